// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kabeta_pipe_pkg
// Purpose  : Shared types and PcSel codes for the Beta pipeline hazard
//            sequencer (state encoding, PC-source selector values).
// Revision : 1.0  initial release
// ============================================================================
package kabeta_pipe_pkg;

  // Sequencer state: reset flush, normal run, one-cycle exception entry
  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_RUN = 2'd1,
    ST_EXC = 2'd2
  } state_t;

  // PC-source select codes
  localparam int PCSEL_NEXT = 0;  // PC+4
  localparam int PCSEL_BR   = 1;  // branch / JMP target
  localparam int PCSEL_ILL  = 2;  // illegal-op vector
  localparam int PCSEL_IRQ  = 3;  // interrupt vector
  localparam int PCSEL_RST  = 4;  // reset vector

  // Blanking counter width covers the 0..15 range of EXC_BLANK
  localparam int BLANK_W = 4;

endpackage : kabeta_pipe_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Purpose  : Bundle of hazard inputs from the datapath and stage control
//            outputs back to the IF/RF/ALU instruction registers.
//            master = datapath side, slave = hazard sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int PCSEL_W = 3
);
  import kabeta_pipe_pkg::*;

  // Hazard / event inputs to the sequencer
  logic               IrqReq;
  logic               SupMode;
  logic               IllOp;
  logic               BranchTaken;
  logic               LdUseHazard;
  logic               MemBusy;

  // Stage controls from the sequencer
  logic               IF_Enable;
  logic               RF_Enable;
  logic               ALU_Enable;
  logic               IF_Flush;
  logic               RF_Flush;
  logic               ALU_Flush;
  logic               ExcAck;
  logic [PCSEL_W-1:0] PcSel;
  logic               IrqAck;

  modport master (
    output IrqReq, SupMode, IllOp, BranchTaken, LdUseHazard, MemBusy,
    input  IF_Enable, RF_Enable, ALU_Enable, IF_Flush, RF_Flush, ALU_Flush,
    input  ExcAck, PcSel, IrqAck
  );

  modport slave (
    input  IrqReq, SupMode, IllOp, BranchTaken, LdUseHazard, MemBusy,
    output IF_Enable, RF_Enable, ALU_Enable, IF_Flush, RF_Flush, ALU_Flush,
    output ExcAck, PcSel, IrqAck
  );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync
// Purpose  : Two-flop synchroniser for an asynchronous level interrupt
//            request. Both flops clear on synchronous active-low reset.
// Revision : 1.0  initial release
// ============================================================================
module irq_sync (
  input  wire logic Clock,
  input  wire logic Reset_n,
  input  wire logic d,
  output logic      q
);
  import kabeta_pipe_pkg::*;

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the request into the Clock domain
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : irq_sync
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central sequencer for the IF/RF/ALU instruction registers of
//            the Beta pipeline. Resolves memory stalls, load-use hazards,
//            taken branches, illegal ops and interrupts, and drives per-stage
//            Enable/Flush, ExcAck and the PC-source select.
// Config   : KABETA_IRQ_SYNC_EN - route IrqReq through a 2-flop
//            synchroniser (adds 2 cycles of interrupt latency).
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int EXC_BLANK = 2,
  parameter int PCSEL_W   = 3
) (
  input  wire logic             Clock,
  input  wire logic             Reset_n,
  pipeline_hazard_ctrl_if.slave bus
);
  import kabeta_pipe_pkg::*;

  localparam logic [BLANK_W-1:0] c_blank_init = BLANK_W'(EXC_BLANK);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [BLANK_W-1:0] w_blank_cnt_nxt;

  logic               w_irq;
  logic               w_irq_take;

  logic               w_if_en;
  logic               w_rf_en;
  logic               w_alu_en;
  logic               w_if_fl;
  logic               w_rf_fl;
  logic               w_alu_fl;
  logic               w_exc_ack;
  logic               w_irq_ack;
  logic [PCSEL_W-1:0] w_pcsel;

`ifdef KABETA_IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (bus.IrqReq),
    .q       (w_irq)
  );
`else
  // Request is already synchronous to Clock
  assign w_irq = bus.IrqReq;
`endif

  // An interrupt is only eligible in user mode once the post-exception
  // blanking window has fully expired.
  assign w_irq_take = w_irq & ~bus.SupMode & (r_blank_cnt == '0);

  // State and blanking counter registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state     <= ST_RST;
      r_blank_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
    end
  end

  // Next-state, blanking counter and stage-control decode by priority
  always_comb begin
    w_state_nxt     = r_state;
    w_blank_cnt_nxt = r_blank_cnt;
    w_if_en         = 1'b1;
    w_rf_en         = 1'b1;
    w_alu_en        = 1'b1;
    w_if_fl         = 1'b0;
    w_rf_fl         = 1'b0;
    w_alu_fl        = 1'b0;
    w_exc_ack       = 1'b0;
    w_irq_ack       = 1'b0;
    w_pcsel         = PCSEL_W'(PCSEL_NEXT);

    unique case (r_state)
      ST_RST: begin
        // Flush every stage and fetch from the reset vector
        w_if_fl     = 1'b1;
        w_rf_fl     = 1'b1;
        w_alu_fl    = 1'b1;
        w_pcsel     = PCSEL_W'(PCSEL_RST);
        w_state_nxt = ST_RUN;
      end

      ST_RUN: begin
        if (bus.MemBusy) begin
          // Freeze the whole pipe; any exception waits for memory
          w_if_en  = 1'b0;
          w_rf_en  = 1'b0;
          w_alu_en = 1'b0;
        end else begin
          if (r_blank_cnt != '0) begin
            w_blank_cnt_nxt = r_blank_cnt - 1'b1;
          end

          if (bus.IllOp) begin
            // RF instr becomes BNE(R31,0,XP); younger IF instr is squashed
            w_if_fl     = 1'b1;
            w_rf_fl     = 1'b1;
            w_exc_ack   = 1'b1;
            w_pcsel     = PCSEL_W'(PCSEL_ILL);
            w_state_nxt = ST_EXC;
          end else if (w_irq_take) begin
            w_if_fl     = 1'b1;
            w_rf_fl     = 1'b1;
            w_exc_ack   = 1'b1;
            w_irq_ack   = 1'b1;
            w_pcsel     = PCSEL_W'(PCSEL_IRQ);
            w_state_nxt = ST_EXC;
          end else if (bus.BranchTaken) begin
            // Wrong-path fetch is discarded; a load-use on it is moot
            w_if_fl = 1'b1;
            w_pcsel = PCSEL_W'(PCSEL_BR);
          end else if (bus.LdUseHazard) begin
            // Hold IF/RF and push a bubble into ALU
            w_if_en  = 1'b0;
            w_rf_en  = 1'b0;
            w_alu_fl = 1'b1;
          end
        end
      end

      ST_EXC: begin
        // Discard the fetch made from the old stream, arm blanking
        w_if_fl         = 1'b1;
        w_blank_cnt_nxt = c_blank_init;
        w_state_nxt     = ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  assign bus.IF_Enable  = w_if_en;
  assign bus.RF_Enable  = w_rf_en;
  assign bus.ALU_Enable = w_alu_en;
  assign bus.IF_Flush   = w_if_fl;
  assign bus.RF_Flush   = w_rf_fl;
  assign bus.ALU_Flush  = w_alu_fl;
  assign bus.ExcAck     = w_exc_ack;
  assign bus.PcSel      = w_pcsel;
  assign bus.IrqAck     = w_irq_ack;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed-vector scoreboard bench for pipeline_hazard_ctrl.
//            Expected stage controls are hand-built constants queued per
//            cycle; a monitor pops and compares one entry every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
  import kabeta_pipe_pkg::*;

  // {IF_En, RF_En, ALU_En, IF_Fl, RF_Fl, ALU_Fl, ExcAck, PcSel[2:0], IrqAck}
  typedef logic [10:0] exp_t;

  localparam exp_t E_RST   = 11'b111_111_0_100_0;
  localparam exp_t E_NORM  = 11'b111_000_0_000_0;
  localparam exp_t E_STALL = 11'b000_000_0_000_0;
  localparam exp_t E_ILL   = 11'b111_110_1_010_0;
  localparam exp_t E_IRQ   = 11'b111_110_1_011_1;
  localparam exp_t E_BR    = 11'b111_100_0_001_0;
  localparam exp_t E_LDU   = 11'b001_001_0_000_0;
  localparam exp_t E_EXC   = 11'b111_100_0_000_0;

`ifdef KABETA_IRQ_SYNC_EN
  localparam int IRQ_LAT = 2;
`else
  localparam int IRQ_LAT = 0;
`endif

  typedef struct {
    exp_t  e;
    string name;
  } sb_t;

  logic Clock;
  logic Reset_n;
  sb_t  sb[$];
  int   n_vec;
  int   n_err;

  pipeline_hazard_ctrl_if #(.PCSEL_W(3)) bus ();

  pipeline_hazard_ctrl #(
    .EXC_BLANK (2),
    .PCSEL_W   (3)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Apply one cycle of inputs and queue the expected stage controls
  task automatic vec(input logic rn, input logic irq, input logic sup,
                     input logic ill, input logic br, input logic ldu,
                     input logic mb, input exp_t e, input string name);
    sb_t item;
    @(posedge Clock);
    #1;
    Reset_n         = rn;
    bus.IrqReq      = irq;
    bus.SupMode     = sup;
    bus.IllOp       = ill;
    bus.BranchTaken = br;
    bus.LdUseHazard = ldu;
    bus.MemBusy     = mb;
    item.e          = e;
    item.name       = name;
    sb.push_back(item);
  endtask

  // Monitor: one comparison per cycle, sampled on the falling edge
  initial begin
    sb_t  item;
    exp_t act;
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        act  = {bus.IF_Enable, bus.RF_Enable, bus.ALU_Enable,
                bus.IF_Flush, bus.RF_Flush, bus.ALU_Flush,
                bus.ExcAck, bus.PcSel, bus.IrqAck};
        n_vec++;
        if (act !== item.e) begin
          n_err++;
          $display("FAIL %s: got %b required %b (t=%0t)", item.name, act, item.e, $time);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    n_vec           = 0;
    n_err           = 0;
    Reset_n         = 1'b0;
    bus.IrqReq      = 1'b0;
    bus.SupMode     = 1'b0;
    bus.IllOp       = 1'b0;
    bus.BranchTaken = 1'b0;
    bus.LdUseHazard = 1'b0;
    bus.MemBusy     = 1'b0;

    // Reset, release, first RUN cycle
    vec(0,0,0,0,0,0,0, E_RST,  "rst_low1");
    vec(0,0,0,0,0,0,0, E_RST,  "rst_low2");
    vec(1,0,0,0,0,0,0, E_RST,  "rst_first_cycle");
    vec(1,0,0,0,0,0,0, E_NORM, "run_normal");

    // Load-use bubble then recovery
    vec(1,0,0,0,0,1,0, E_LDU,  "lduse");
    vec(1,0,0,0,0,0,0, E_NORM, "lduse_after");

    // Branch beats load-use
    vec(1,0,0,0,1,1,0, E_BR,   "branch_over_lduse");
    vec(1,0,0,0,1,0,0, E_BR,   "branch");
    vec(1,0,0,0,0,0,0, E_NORM, "branch_after");

    // Interrupt take, blanking, retake
    for (int i = 0; i < IRQ_LAT; i++) vec(1,1,0,0,0,0,0, E_NORM, "irq_sync_lat");
    vec(1,1,0,0,0,0,0, E_IRQ,  "irq_take");
    vec(1,1,0,0,0,0,0, E_EXC,  "irq_exc");
    vec(1,1,0,0,0,0,0, E_NORM, "irq_blank1");
    vec(1,1,0,0,0,0,0, E_NORM, "irq_blank2");
    vec(1,1,0,0,0,0,0, E_IRQ,  "irq_retake");
    vec(1,1,0,0,0,0,0, E_EXC,  "irq_retake_exc");
    vec(1,0,0,0,0,0,0, E_NORM, "irq_drop_blank1");
    vec(1,0,0,0,0,0,0, E_NORM, "irq_drop_blank2");
    vec(1,0,0,0,0,0,0, E_NORM, "irq_idle");

    // Supervisor mode masks interrupts
    for (int i = 0; i < 5; i++) vec(1,1,1,0,0,0,0, E_NORM, "sup_mask");
    for (int i = 0; i < IRQ_LAT + 1; i++) vec(1,0,1,0,0,0,0, E_NORM, "sup_release");

    // IllOp held under MemBusy, then taken; EXC ignores a new IllOp
    vec(1,0,0,1,0,0,1, E_STALL, "ill_stall1");
    vec(1,0,0,1,0,0,1, E_STALL, "ill_stall2");
    vec(1,0,0,1,0,0,1, E_STALL, "ill_stall3");
    vec(1,0,0,1,0,0,0, E_ILL,   "ill_take");
    vec(1,0,0,1,0,0,0, E_EXC,   "ill_exc_no_new");
    vec(1,0,0,0,0,0,0, E_NORM,  "ill_blank1");
    vec(1,0,0,0,0,0,0, E_NORM,  "ill_blank2");

    // IllOp beats irq; irq stays pending; MemBusy freezes blanking
    for (int i = 0; i < IRQ_LAT; i++) vec(1,1,0,0,0,0,0, E_NORM, "irq_sync_lat2");
    vec(1,1,0,1,0,0,0, E_ILL,   "ill_over_irq");
    vec(1,1,0,0,0,0,0, E_EXC,   "ill_over_irq_exc");
    vec(1,1,0,0,0,0,0, E_NORM,  "pend_blank_2to1");
    vec(1,1,0,0,0,0,1, E_STALL, "pend_freeze1");
    vec(1,1,0,0,0,0,1, E_STALL, "pend_freeze2");
    vec(1,1,0,0,0,0,0, E_NORM,  "pend_blank_1to0");
    vec(1,1,0,0,0,0,0, E_IRQ,   "pend_irq_take");
    vec(1,0,0,0,0,0,0, E_EXC,   "pend_irq_exc");
    vec(1,0,0,0,0,0,0, E_NORM,  "pend_post1");
    vec(1,0,0,0,0,0,0, E_NORM,  "pend_post2");
    vec(1,0,0,0,0,0,0, E_NORM,  "pend_post3");

    // Reset during EXC: RST outputs, no IrqAck, then irq taken in RUN
    vec(1,0,0,1,0,0,0, E_ILL,  "pre_rst_ill");
    vec(0,0,0,0,0,0,0, E_EXC,  "rst_in_exc");
    vec(1,1,0,0,0,0,0, E_RST,  "rst_no_irqack");
    for (int i = 1; i < IRQ_LAT; i++) vec(1,1,0,0,0,0,0, E_NORM, "irq_sync_lat3");
    vec(1,1,0,0,0,0,0, E_IRQ,  "irq_after_reset");
    vec(1,0,0,0,0,0,0, E_EXC,  "irq_after_reset_exc");
    vec(1,0,0,0,0,0,0, E_NORM, "post_reset_blank1");
    vec(1,0,0,0,0,0,0, E_NORM, "post_reset_blank2");

    // Reset during a memory stall
    vec(1,0,0,0,0,0,1, E_STALL, "stall");
    vec(0,0,0,0,0,0,1, E_STALL, "rst_in_stall");
    vec(1,0,0,0,0,0,1, E_RST,   "rst_over_membusy");
    vec(1,0,0,0,0,0,0, E_NORM,  "final_normal");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clock);
    @(posedge Clock);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
